daric_host_sequencer: RTL and testbench
=======================================

Name: daric_host_sequencer

Overview:
- Host-side transmitter that generates the 39-bit host_controller command word consumed by the Daric CGRA top level.
- Buffers configuration entries from a host/DMA valid-ready stream and replays them as one-cycle init strobes to the PE groups or the scratchpad.
- Then asserts run for a programmed cycle count and signals completion.
- Sits between the SoC host interface and the Daric host_controller input.

Parameters:
- INST_W, 28, instruction field width (PE_inst).
- PE_GRP, 9, number of init_PE_array strobe bits.
- FIFO_DEPTH, 16, configuration FIFO entries (power of two).
- CNT_W, 16, run-length counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration entry valid.
- cfg_ready  out  1  FIFO can accept; equals !full.
- cfg_target  in  4  entry target: 0..8 = PE group bit, 9 = SPM, 10..15 = illegal.
- cfg_inst  in  INST_W  instruction payload.
- start  in  1  launch load+run sequence; ignored while busy.
- run_len  in  CNT_W  run cycles; sampled when start is accepted.
- abort  in  1  synchronous abort.
- host_controller  out  39  {run[38], init_SPM[37], init_PE_array[36:28], instruction[27:0]}; fully registered.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky illegal-target flag.

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, host_controller=0, done=0, err=0, busy=0. cfg_ready=1 as soon as the FIFO is empty.
- FIFO push:
  - Push on cfg_valid && cfg_ready, in any state (including LOAD and RUN).
  - When full, cfg_ready=0 and cfg_valid is held off. No overwrite.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 latches run_len into the counter and clears err.
  - If the FIFO is empty and run_len==0, go to DONE. Otherwise go to LOAD.
- LOAD:
  - Each cycle with the FIFO non-empty: pop the head.
  - The next cycle drives instruction=cfg_inst and exactly one strobe for that single cycle: init_PE_array[target] for target 0..8, or init_SPM for target 9.
  - Illegal target: entry discarded, err set, all strobes 0, instruction=0.
  - FIFO empty: go to RUN if the counter != 0, else go to DONE.
  - Pushes arriving during LOAD extend the load phase.
- RUN:
  - run=1, init strobes 0, instruction=0.
  - Counter decrements each cycle. run stays high for exactly run_len cycles, then the state goes to DONE.
- DONE: done=1 for one cycle; host_controller=0; next state IDLE.
- Timing (start accepted at cycle 0, N FIFO entries, L=run_len):
  - Pops at cycles 1..N.
  - Strobes visible at cycles 2..N+1.
  - run visible at cycles N+2..N+1+L.
  - done at cycle N+2+L.
  - N=0, L=0: done at cycle 1.
  - N>0, L=0: done at cycle N+2.
- Invariants:
  - Never more than one init bit set.
  - init and run never asserted in the same cycle.
  - instruction is nonzero only alongside an init strobe.
- abort (any state, highest priority after reset): next cycle state IDLE, host_controller=0, FIFO flushed, done not pulsed, err preserved.
- Simultaneous abort and start in IDLE: abort wins.
- Simultaneous push and pop: both occur; the occupancy count is unchanged.
- Counter wrap: run_len=2^CNT_W-1 runs exactly that many cycles with no wrap.

Test Plan:
1. Reset mid-RUN → all outputs 0 immediately, cfg_ready=1; a subsequent start with empty FIFO and run_len=0 → done at cycle 1.
2. Push 3 entries {t=0, 0x0000001}, {t=8, 0x0ABCDEF}, {t=9, 0x0000123}; start with run_len=4 → cycle 2: init_PE_array=9'h001, instruction=0x0000001; cycle 3: 9'h100, 0x0ABCDEF; cycle 4: init_SPM=1, 0x0000123; run high cycles 5–8; done at cycle 9.
3. Fill 16 entries → cfg_ready=0 on the 17th offer. Start → cfg_ready returns to 1 the cycle after the first pop. Keep pushing during LOAD → all 16+k strobes appear back-to-back, in order.
4. Entry with target=12 between two legal entries → no strobe in its slot, err=1 persisting after done; next start clears err.
5. abort at the 2nd RUN cycle (run_len=10) → run=0 next cycle, busy=0, no done pulse. FIFO loaded with 2 entries during RUN is empty afterward.
6. start asserted while busy → ignored. After done, start with run_len=0 and 1 entry → strobe at cycle 2, done at cycle 3, run never high.

Source files
------------

// File: rtl/daric_host_sequencer.sv
// Host-side sequencer for the Daric CGRA: buffers configuration entries, replays them as
// one-cycle init strobes on host_controller, then drives run for a programmed cycle count.
module daric_host_sequencer #(
   parameter int INST_W     = 28,
   parameter int PE_GRP     = 9,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [3:0]                 cfg_target,
   input  logic [INST_W-1:0]          cfg_inst,
   input  logic                       start,
   input  logic [CNT_W-1:0]           run_len,
   input  logic                       abort,
   output logic [PE_GRP+INST_W+1:0]   host_controller,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   // state  | meaning
   // IDLE   | waiting for start; FIFO still accepts entries
   // LOAD   | popping one entry per cycle, strobe appears the following cycle
   // RUN    | run asserted, counter decrements to terminal count 1
   // DONE   | one-cycle done pulse
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   localparam int              PTR_W   = $clog2(FIFO_DEPTH);
   localparam int              HC_W    = PE_GRP + INST_W + 2;
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [3:0]      SPM_TGT = 4'(PE_GRP);

   logic [3+INST_W:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      count_q, count_d;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [HC_W-1:0]     hc_q, hc_d;
   logic                done_q, done_d, err_q, err_d;
   logic                push, pop, fifo_empty;
   logic [3:0]          head_tgt;
   logic [INST_W-1:0]   head_inst;
   logic [PE_GRP-1:0]   pe_onehot;

   assign fifo_empty            = (count_q == '0);
   assign cfg_ready             = (count_q != DEPTH_C);
   assign push                  = cfg_valid && cfg_ready;
   assign {head_tgt, head_inst} = mem_q[rd_ptr_q];
   assign pe_onehot             = {{(PE_GRP-1){1'b0}}, 1'b1} << head_tgt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hc_d    = '0;
      done_d  = 1'b0;
      err_d   = err_q;
      pop     = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               cnt_d = run_len;
               err_d = 1'b0;
               if (fifo_empty && run_len == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
            S_LOAD: if (!fifo_empty) begin
               pop = 1'b1;
               // illegal targets are consumed without a strobe
               if (head_tgt < SPM_TGT)       hc_d = {2'b00, pe_onehot, head_inst};
               else if (head_tgt == SPM_TGT) hc_d = {2'b01, {PE_GRP{1'b0}}, head_inst};
               else                          err_d = 1'b1;
            end else if (cnt_q != '0) begin
               state_d          = S_RUN;
               hc_d[HC_W-1]     = 1'b1;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
            S_RUN: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  hc_d[HC_W-1] = 1'b1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
         else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cfg_target, cfg_inst};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hc_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hc_q     <= hc_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign host_controller = hc_q;
   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign err             = err_q;

endmodule

// File: tb/tb_daric_host_sequencer.sv
// Self-checking bench for daric_host_sequencer: vector table, hand-written corner sequences
// and random traffic compared against a schedule-based reference model.
module tb_daric_host_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid, cfg_ready, start, abort, busy, done, err;
   logic [3:0]  cfg_target;
   logic [27:0] cfg_inst;
   logic [15:0] run_len;
   logic [38:0] host_controller;

   always #5 clk = ~clk;

   daric_host_sequencer #(.INST_W(28), .PE_GRP(9), .FIFO_DEPTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_target(cfg_target), .cfg_inst(cfg_inst), .start(start), .run_len(run_len),
      .abort(abort), .host_controller(host_controller), .busy(busy), .done(done), .err(err)
   );

   typedef struct { logic [38:0] hc; logic dn; } word_t;
   typedef struct { logic [3:0] tgt; logic [27:0] inst; } entry_t;
   typedef struct {
      logic valid; logic [3:0] tgt; logic [27:0] inst; logic st; logic [15:0] len;
      logic [38:0] e_hc; logic e_done; logic e_busy;
   } vec_t;

   localparam logic [38:0] RUN_W = 39'h40_0000_0000;

   int     n_checks = 0;
   int     n_errors = 0;
   entry_t mq[$];
   word_t  sched[$];
   bit     m_drain, m_busy;
   int     m_len;
   logic   m_err;
   word_t  m_cur;
   vec_t   vt[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [38:0] strobe_word(input logic [3:0] t, input logic [27:0] i);
      logic [38:0] w = '0;
      if (t < 4'd9)       w[28 + int'(t)] = 1'b1;
      else if (t == 4'd9) w[37] = 1'b1;
      else                return '0;
      w[27:0] = i;
      return w;
   endfunction

   function automatic void model_reset();
      mq.delete(); sched.delete();
      m_drain = 0; m_busy = 0; m_len = 0; m_err = 1'b0;
      m_cur.hc = '0; m_cur.dn = 1'b0;
   endfunction

   // Expected outputs come from a schedule of future words built when work is accepted.
   function automatic void model_step();
      bit    push_ok = cfg_valid && (mq.size() < 16);
      bit    from_sched = 0;
      word_t w;
      entry_t e;
      if (abort) begin
         mq.delete(); sched.delete();
         m_drain = 0; m_busy = 0; m_cur.hc = '0; m_cur.dn = 1'b0;
         return;
      end
      if (!m_busy) begin
         if (start) begin
            m_err = 1'b0;
            m_len = int'(run_len);
            if (mq.size() == 0 && m_len == 0) begin
               w.hc = '0; w.dn = 1'b1; sched.push_back(w);
            end else m_drain = 1;
         end
      end else if (m_drain) begin
         if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.tgt > 4'd9) m_err = 1'b1;
            w.hc = strobe_word(e.tgt, e.inst); w.dn = 1'b0;
            sched.push_back(w);
         end else begin
            m_drain = 0;
            for (int k = 0; k < m_len; k++) begin
               w.hc = RUN_W; w.dn = 1'b0; sched.push_back(w);
            end
            w.hc = '0; w.dn = 1'b1; sched.push_back(w);
         end
      end
      if (push_ok) begin
         e.tgt = cfg_target; e.inst = cfg_inst; mq.push_back(e);
      end
      if (sched.size() > 0) begin
         m_cur = sched.pop_front(); from_sched = 1;
      end else begin
         m_cur.hc = '0; m_cur.dn = 1'b0;
      end
      m_busy = m_drain || from_sched;
   endfunction

   task automatic tick();
      logic inv_ok;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_hc", 64'(host_controller), 64'(m_cur.hc));
      chk("model_done", 64'(done), 64'(m_cur.dn));
      chk("model_busy", 64'(busy), 64'(m_busy));
      chk("model_err", 64'(err), 64'(m_err));
      chk("model_cfg_ready", 64'(cfg_ready), 64'(mq.size() < 16));
      inv_ok = ($countones(host_controller[37:28]) <= 1) &&
               !(host_controller[38] && (host_controller[37:28] != '0)) &&
               !((host_controller[27:0] != '0) && (host_controller[37:28] == '0));
      chk("invariants", 64'(inv_ok), 64'(1));
   endtask

   task automatic clear_inputs();
      cfg_valid = 0; cfg_target = '0; cfg_inst = '0; start = 0; run_len = '0; abort = 0;
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int c = 0; c < max_cycles && busy; c++) tick();
      chk("idle_timeout", 64'(busy), 64'(0));
   endtask

   task automatic push_one(input logic [3:0] t, input logic [27:0] i);
      cfg_valid = 1; cfg_target = t; cfg_inst = i;
      tick();
      cfg_valid = 0;
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] t, input logic [27:0] i,
                               input logic s, input logic [15:0] l, input logic [38:0] h,
                               input logic d, input logic b);
      vec_t r;
      r.valid = v; r.tgt = t; r.inst = i; r.st = s; r.len = l;
      r.e_hc = h; r.e_done = d; r.e_busy = b;
      return r;
   endfunction

   initial begin
      int strobes, cur_run, max_run, pushed, any_done;
      logic rdy_before;

      vt[0]  = mk(1, 4'd0, 28'h0000001, 0, 16'd0, '0, 0, 0);
      vt[1]  = mk(1, 4'd8, 28'h0ABCDEF, 0, 16'd0, '0, 0, 0);
      vt[2]  = mk(1, 4'd9, 28'h0000123, 0, 16'd0, '0, 0, 0);
      vt[3]  = mk(0, 4'd0, 28'h0, 1, 16'd4, '0, 0, 1);
      vt[4]  = mk(0, 4'd0, 28'h0, 0, 16'd0, 39'h00_1000_0001, 0, 1);
      vt[5]  = mk(0, 4'd0, 28'h0, 0, 16'd0, 39'h10_00AB_CDEF, 0, 1);
      vt[6]  = mk(0, 4'd0, 28'h0, 0, 16'd0, 39'h20_0000_0123, 0, 1);
      vt[7]  = mk(0, 4'd0, 28'h0, 0, 16'd0, RUN_W, 0, 1);
      vt[8]  = mk(0, 4'd0, 28'h0, 0, 16'd0, RUN_W, 0, 1);
      vt[9]  = mk(0, 4'd0, 28'h0, 0, 16'd0, RUN_W, 0, 1);
      vt[10] = mk(0, 4'd0, 28'h0, 0, 16'd0, RUN_W, 0, 1);
      vt[11] = mk(0, 4'd0, 28'h0, 0, 16'd0, '0, 1, 1);
      vt[12] = mk(0, 4'd0, 28'h0, 0, 16'd0, '0, 0, 0);

      clear_inputs();
      rst = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_hc", 64'(host_controller), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_err", 64'(err), 64'(0));
      chk("reset_ready", 64'(cfg_ready), 64'(1));
      rst = 1;

      // Three entries then a four-cycle run
      for (int i = 0; i < 13; i++) begin
         cfg_valid = vt[i].valid; cfg_target = vt[i].tgt; cfg_inst = vt[i].inst;
         start = vt[i].st; run_len = vt[i].len;
         tick();
         chk("vec_hc", 64'(host_controller), 64'(vt[i].e_hc));
         chk("vec_done", 64'(done), 64'(vt[i].e_done));
         chk("vec_busy", 64'(busy), 64'(vt[i].e_busy));
      end
      clear_inputs();

      // Full FIFO, then back-to-back strobes while more entries stream in
      for (int i = 0; i < 16; i++) push_one(4'($urandom_range(9, 0)), 28'($urandom));
      cfg_valid = 1; cfg_target = 4'd2; cfg_inst = 28'h1234567;
      chk("full_ready", 64'(cfg_ready), 64'(0));
      start = 1; run_len = 16'd2;
      tick();
      start = 0;
      chk("ready_after_start", 64'(cfg_ready), 64'(0));
      strobes = 0; cur_run = 0; max_run = 0; pushed = 0;
      for (int c = 0; c < 200 && busy; c++) begin
         cfg_valid = (pushed < 5);
         cfg_target = 4'($urandom_range(9, 0)); cfg_inst = 28'($urandom);
         rdy_before = cfg_ready;
         tick();
         if (cfg_valid && rdy_before) pushed++;
         if (c == 0) chk("ready_after_pop", 64'(cfg_ready), 64'(1));
         if (host_controller[37:28] != '0) begin
            strobes++; cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else cur_run = 0;
      end
      chk("idle_timeout", 64'(busy), 64'(0));
      chk("stream_strobes", 64'(strobes), 64'(21));
      chk("stream_back_to_back", 64'(max_run), 64'(21));
      clear_inputs();

      // Illegal target between two legal ones
      push_one(4'd0, 28'h0000011);
      push_one(4'd12, 28'h0000022);
      push_one(4'd1, 28'h0000033);
      start = 1; run_len = 16'd2;
      tick();
      start = 0;
      tick();
      chk("illegal_pre", 64'(host_controller), 64'(39'h00_1000_0011));
      tick();
      chk("illegal_slot", 64'(host_controller), 64'(0));
      chk("illegal_err", 64'(err), 64'(1));
      tick();
      chk("illegal_post", 64'(host_controller), 64'(39'h00_2000_0033));
      wait_idle(50);
      chk("err_sticky", 64'(err), 64'(1));
      start = 1; run_len = 16'd0;
      tick();
      start = 0;
      chk("err_cleared", 64'(err), 64'(0));
      chk("empty_done_c1", 64'(done), 64'(1));
      tick();

      // Abort at the second RUN cycle with entries queued during the run
      start = 1; run_len = 16'd10;
      tick();
      start = 0;
      cfg_valid = 1; cfg_target = 4'd4; cfg_inst = 28'h0000AAA;
      tick();
      chk("abort_run1", 64'(host_controller[38]), 64'(1));
      cfg_target = 4'd9; cfg_inst = 28'h0000BBB;
      tick();
      cfg_valid = 0;
      abort = 1;
      tick();
      abort = 0;
      chk("abort_run_low", 64'(host_controller[38]), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      any_done = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done) any_done = 1;
      end
      chk("abort_no_done", 64'(any_done), 64'(0));
      start = 1; run_len = 16'd0;
      tick();
      start = 0;
      chk("abort_flushed", 64'(done), 64'(1));
      tick();

      // start while busy is ignored
      start = 1; run_len = 16'd3;
      tick();
      for (int c = 1; c <= 5; c++) begin
         start = 1; run_len = 16'd50;
         tick();
         chk("ignored_start_done", 64'(done), 64'(c == 4));
      end
      start = 0;
      chk("ignored_start_idle", 64'(busy), 64'(0));
      push_one(4'd3, 28'h0000777);
      start = 1; run_len = 16'd0;
      tick();
      start = 0;
      tick();
      chk("len0_strobe", 64'(host_controller), 64'(39'h00_8000_0777));
      tick();
      chk("len0_done", 64'(done), 64'(1));
      chk("len0_no_run", 64'(host_controller[38]), 64'(0));
      tick();

      // Reset in the middle of RUN with a full FIFO
      start = 1; run_len = 16'd40;
      tick();
      start = 0;
      cfg_valid = 1;
      for (int i = 0; i < 17; i++) begin
         cfg_target = 4'($urandom_range(15, 0)); cfg_inst = 28'($urandom);
         tick();
      end
      cfg_valid = 0;
      chk("midrun_full", 64'(cfg_ready), 64'(0));
      rst = 0;
      #1;
      chk("midrun_rst_hc", 64'(host_controller), 64'(0));
      chk("midrun_rst_busy", 64'(busy), 64'(0));
      chk("midrun_rst_ready", 64'(cfg_ready), 64'(1));
      chk("midrun_rst_done", 64'(done), 64'(0));
      model_reset();
      @(negedge clk);
      rst = 1;
      start = 1; run_len = 16'd0;
      tick();
      start = 0;
      chk("post_rst_done_c1", 64'(done), 64'(1));
      tick();

      // Random traffic against the reference model
      for (int c = 0; c < 4000; c++) begin
         abort = ($urandom_range(99, 0) < 2);
         cfg_valid = !abort && ($urandom_range(1, 0) == 1);
         cfg_target = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 10))
                                                   : 4'($urandom_range(9, 0));
         cfg_inst = 28'($urandom);
         start = ($urandom_range(9, 0) == 0);
         run_len = 16'($urandom_range(6, 0));
         tick();
      end
      clear_inputs();
      wait_idle(200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
